lbdr_input_fifo: RTL and testbench

First-word-fall-through input buffer for one router input port, directly upstream of the port's LBDR routing stage. It accepts flits from the link, stores them in a small circular FIFO, and presents the head flit's `empty`, `flit_id` and `dst_addr` fields to LBDR every cycle. It returns one credit per flit consumed and checks packet framing (HEADER → PAYLOAD* → TAIL) on the incoming stream.

---
 rtl/lbdr_input_fifo_if.sv | 27 ++
 rtl/lbdr_input_fifo.sv | 127 ++++++++++++
 tb/tb_lbdr_input_fifo.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lbdr_input_fifo_if.sv
// Link-side and LBDR-side signals of one router input buffer.
// The FIFO sits on the slave side. The link/switch environment sits on the master side.
interface lbdr_input_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic [2:0]            flit_id;
    logic [3:0]            dst_addr;
    logic                  empty;
    logic                  full;
    logic                  credit_out;
    logic                  overflow;
    logic                  frame_err;

    modport master (
        output rx_valid, rx_data, read_en,
        input  data_out, flit_id, dst_addr, empty, full, credit_out, overflow, frame_err
    );

    modport slave (
        input  rx_valid, rx_data, read_en,
        output data_out, flit_id, dst_addr, empty, full, credit_out, overflow, frame_err
    );
endinterface

// File: rtl/lbdr_input_fifo.sv
// First-word-fall-through input FIFO feeding an LBDR routing stage.
// Returns one credit per popped flit and checks HEADER/PAYLOAD/TAIL framing on stored flits.
module lbdr_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                clk,
    input  logic                rst,
    lbdr_input_fifo_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;

    typedef enum logic {
        ST_IDLE,
        ST_IN_PKT
    } frame_state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          credit_q, credit_d;
    logic          overflow_q, overflow_d;
    logic          frame_err_q, frame_err_d;
    frame_state_t  state_q, state_d;

    logic          wr_accept;
    logic          rd_accept;
    logic [2:0]    rx_type;

    assign wr_accept = bus.rx_valid && !full_q;
    assign rd_accept = bus.read_en && !empty_q;
    assign rx_type   = bus.rx_data[31:29];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        frame_err_d = frame_err_q;
        state_d     = state_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // A pop in the same cycle does not free a slot for an arriving flit: full_q is the gate.
        if (bus.rx_valid && full_q) begin
            overflow_d = 1'b1;
        end

        count_d  = count_q + CW'(wr_accept) - CW'(rd_accept);
        empty_d  = (count_d == '0);
        full_d   = (count_d == CW'(DEPTH));
        credit_d = rd_accept;

        // Framing is judged only on flits that are actually stored; bad flits are still buffered.
        if (wr_accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_type == HEADER) begin
                        state_d = ST_IN_PKT;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                ST_IN_PKT: begin
                    if (rx_type == TAIL) begin
                        state_d = ST_IDLE;
                    end else if (rx_type != PAYLOAD) begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            credit_q    <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            state_q     <= ST_IDLE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            credit_q    <= credit_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            state_q     <= state_d;
        end
    end

    // Storage is deliberately left out of reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= bus.rx_data;
        end
    end

    assign bus.data_out   = mem_q[rd_ptr_q];
    assign bus.flit_id    = bus.data_out[31:29];
    assign bus.dst_addr   = bus.data_out[28:25];
    assign bus.empty      = empty_q;
    assign bus.full       = full_q;
    assign bus.credit_out = credit_q;
    assign bus.overflow   = overflow_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_lbdr_input_fifo.sv
// Directed vector bench for lbdr_input_fifo: table of single-cycle vectors plus
// hand-written reset and framing sequences.
module tb_lbdr_input_fifo;
    localparam logic [2:0] H = 3'b001;
    localparam logic [2:0] P = 3'b010;
    localparam logic [2:0] T = 3'b100;

    typedef struct {
        logic        rx_valid;
        logic [31:0] rx_data;
        logic        read_en;
        logic        e_empty;
        logic        e_full;
        logic        e_credit;
        logic        e_ovf;
        logic        e_ferr;
        logic        chk_data;
        logic [31:0] e_data;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[$];

    lbdr_input_fifo_if #(.DATA_WIDTH(32)) bus ();

    lbdr_input_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [2:0] id, input logic [3:0] dst, input logic [24:0] tag);
        return {id, dst, tag};
    endfunction

    function automatic vec_t v(input logic rv, input logic [31:0] d, input logic rd,
                               input logic ee, input logic ef, input logic ec,
                               input logic eo, input logic efe, input logic cd,
                               input logic [31:0] ed);
        vec_t r;
        r.rx_valid = rv; r.rx_data = d; r.read_en = rd;
        r.e_empty = ee; r.e_full = ef; r.e_credit = ec; r.e_ovf = eo; r.e_ferr = efe;
        r.chk_data = cd; r.e_data = ed;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic ee, input logic ef, input logic ec,
                             input logic eo, input logic efe);
        chk({tag, " empty"},     32'(bus.empty),      32'(ee));
        chk({tag, " full"},      32'(bus.full),       32'(ef));
        chk({tag, " credit"},    32'(bus.credit_out), 32'(ec));
        chk({tag, " overflow"},  32'(bus.overflow),   32'(eo));
        chk({tag, " frame_err"}, 32'(bus.frame_err),  32'(efe));
    endtask

    task automatic step(input string tag, input vec_t x);
        logic [31:0] ed;
        @(negedge clk);
        bus.rx_valid = x.rx_valid;
        bus.rx_data  = x.rx_data;
        bus.read_en  = x.read_en;
        @(posedge clk);
        #1;
        $display("%s rx_valid=%0b rx_data=%h read_en=%0b -> empty=%0b full=%0b credit=%0b ovf=%0b ferr=%0b data_out=%h",
                 tag, x.rx_valid, x.rx_data, x.read_en, bus.empty, bus.full, bus.credit_out,
                 bus.overflow, bus.frame_err, bus.data_out);
        chk_flags(tag, x.e_empty, x.e_full, x.e_credit, x.e_ovf, x.e_ferr);
        if (x.chk_data) begin
            ed = x.e_data;
            chk({tag, " data_out"}, bus.data_out, ed);
            chk({tag, " flit_id"},  32'(bus.flit_id),  32'(ed[31:29]));
            chk({tag, " dst_addr"}, 32'(bus.dst_addr), 32'(ed[28:25]));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus.read_en  = 1'b0;

        // Fill to full, overflow with a concurrent pop, drain, then read while empty.
        vecs.push_back(v(1, mk(H, 4'b1010, 1), 0,  0,0,0,0,0, 1, mk(H, 4'b1010, 1)));
        vecs.push_back(v(1, mk(P, 4'b0000, 2), 0,  0,0,0,0,0, 1, mk(H, 4'b1010, 1)));
        vecs.push_back(v(1, mk(P, 4'b0000, 3), 0,  0,0,0,0,0, 1, mk(H, 4'b1010, 1)));
        vecs.push_back(v(1, mk(T, 4'b0000, 4), 0,  0,1,0,0,0, 1, mk(H, 4'b1010, 1)));
        vecs.push_back(v(1, mk(P, 4'b0000, 5), 1,  0,0,1,1,0, 1, mk(P, 4'b0000, 2)));
        vecs.push_back(v(0, 32'h0,             1,  0,0,1,1,0, 1, mk(P, 4'b0000, 3)));
        vecs.push_back(v(0, 32'h0,             1,  0,0,1,1,0, 1, mk(T, 4'b0000, 4)));
        vecs.push_back(v(0, 32'h0,             1,  1,0,1,1,0, 0, 32'h0));
        vecs.push_back(v(0, 32'h0,             1,  1,0,0,1,0, 0, 32'h0));
        vecs.push_back(v(0, 32'h0,             1,  1,0,0,1,0, 0, 32'h0));
        // Streaming: one flit resident, then write+read every cycle for 10 cycles.
        vecs.push_back(v(1, mk(H, 4'b0101, 10), 0, 0,0,0,1,0, 1, mk(H, 4'b0101, 10)));
        for (int k = 1; k <= 10; k++) begin
            logic [2:0]  ty;
            logic [31:0] d;
            ty = (k == 10) ? T : P;
            d  = mk(ty, 4'(k), 25'(10 + k));
            vecs.push_back(v(1, d, 1, 0,0,1,1,0, 1, d));
        end
        vecs.push_back(v(0, 32'h0, 1, 1,0,1,1,0, 0, 32'h0));
        vecs.push_back(v(0, 32'h0, 0, 1,0,0,1,0, 0, 32'h0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_flags("reset", 1, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset clears sticky overflow; a PAYLOAD first flags frame_err but is still stored.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_flags("rst2", 1, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step("pfirst", v(1, mk(P, 4'b0001, 30), 0, 0,0,0,0,1, 1, mk(P, 4'b0001, 30)));
        step("h1",     v(1, mk(H, 4'b0010, 31), 0, 0,0,0,0,1, 1, mk(P, 4'b0001, 30)));
        step("h2",     v(1, mk(H, 4'b0011, 32), 0, 0,0,0,0,1, 1, mk(P, 4'b0001, 30)));
        step("h3rd",   v(1, mk(H, 4'b0100, 33), 1, 0,0,1,0,1, 1, mk(H, 4'b0010, 31)));
        bus.rx_valid = 1'b0;
        bus.read_en  = 1'b0;

        // Asynchronous reset mid-cycle with 3 flits stored and a credit pulse in flight.
        #1;
        rst = 1'b1;
        #1;
        chk_flags("async_rst", 1, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // FSM must be back in IDLE: HEADER accepted cleanly; read while empty is ignored.
        step("hdr",   v(1, mk(H, 4'b0011, 40), 1, 0,0,0,0,0, 1, mk(H, 4'b0011, 40)));
        step("pay",   v(1, mk(P, 4'b0000, 41), 0, 0,0,0,0,0, 1, mk(H, 4'b0011, 40)));
        step("tail",  v(1, mk(T, 4'b0000, 42), 1, 0,0,1,0,0, 1, mk(P, 4'b0000, 41)));
        step("pop1",  v(0, 32'h0,              1, 0,0,1,0,0, 1, mk(T, 4'b0000, 42)));
        step("pop2",  v(0, 32'h0,              1, 1,0,1,0,0, 0, 32'h0));
        // Undefined flit code in IDLE is a framing error but still buffered.
        step("undef", v(1, mk(3'b111, 4'b1111, 50), 0, 0,0,0,0,1, 1, mk(3'b111, 4'b1111, 50)));
        step("pop3",  v(0, 32'h0,              1, 1,0,1,0,1, 0, 32'h0));
        step("idle",  v(0, 32'h0,              0, 1,0,0,0,1, 0, 32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
